// File: rtl/kbd_pkg.sv
// kbd_pkg: shared PS/2 receiver state encoding and scan-code constants.
package kbd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} ps2_state_e;
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte FIFO with a registered head so dout_o is valid as soon as valid_o rises.
module byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] din_i,
  input  logic       pop_i,
  output logic [7:0] dout_o,
  output logic       valid_o,
  output logic       ovf_o
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [7:0] head_d;
  logic empty, full, do_pop, do_push;
  always_comb begin
    empty = wptr_q == rptr_q;
    full = (wptr_q ^ rptr_q) == {1'b1, {AW{1'b0}}};
    do_pop = pop_i & ~empty;
    do_push = push_i & (~full | do_pop);
    rptr_d = rptr_q + (AW+1)'(do_pop);
    wptr_d = wptr_q + (AW+1)'(do_push);
    // the new head may be the very byte being written this cycle
    head_d = (do_push && rptr_d == wptr_q) ? din_i : mem_q[rptr_d[AW-1:0]];
    valid_o = ~empty;
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wptr_q[AW-1:0]] <= din_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      dout_o <= '0;
      ovf_o <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      dout_o <= head_d;
      ovf_o <= push_i & ~do_push;
    end
endmodule

// File: rtl/ps2_kbd_rx.sv
// ps2_kbd_rx: PS/2 device-to-host frame receiver with break-code filter and scan-code FIFO.
module ps2_kbd_rx
  import kbd_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 12500,
  parameter bit DROP_BREAK = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       kr,
  output logic [7:0] kd,
  output logic       kv,
  output logic       err,
  output logic       overflow
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  ps2_state_e state_q, state_d;
  logic [1:0] clk_s_q, dat_s_q;
  logic clk_prev_q;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic par_ok_q, par_ok_d, brk_q, brk_d, err_q, err_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic fall, din, timeout, accept, push;
  always_comb begin
    fall = clk_prev_q & ~clk_s_q[1];
    din = dat_s_q[1];
    timeout = state_q != ST_IDLE && tcnt_q == TW'(TIMEOUT_CYCLES);
    state_d = state_q;
    bitcnt_d = bitcnt_q;
    shreg_d = shreg_q;
    par_ok_d = par_ok_q;
    accept = 1'b0;
    err_d = timeout;
    tcnt_d = (fall || state_q == ST_IDLE) ? '0 : tcnt_q + TW'(1);
    if (timeout) begin
      state_d = ST_IDLE;
      shreg_d = '0;
    end else if (fall) begin
      case (state_q)
        ST_IDLE: if (!din) begin
          state_d = ST_DATA;
          bitcnt_d = '0;
        end
        ST_DATA: begin
          shreg_d = {din, shreg_q[7:1]};
          bitcnt_d = bitcnt_q + 3'd1;
          state_d = bitcnt_q == 3'd7 ? ST_PARITY : ST_DATA;
        end
        ST_PARITY: begin
          par_ok_d = ^shreg_q ^ din;
          state_d = ST_STOP;
        end
        default: begin
          accept = din & par_ok_q;
          err_d = ~accept;
          state_d = ST_IDLE;
        end
      endcase
    end
    // a break prefix and the byte after it never reach the FIFO
    push = accept & (~DROP_BREAK | (~brk_q & shreg_q != PS2_BREAK));
    brk_d = (DROP_BREAK && accept) ? ~brk_q & (shreg_q == PS2_BREAK) : brk_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_s_q <= 2'b11;
      dat_s_q <= 2'b11;
      clk_prev_q <= 1'b1;
      state_q <= ST_IDLE;
      bitcnt_q <= '0;
      shreg_q <= '0;
      par_ok_q <= 1'b0;
      brk_q <= 1'b0;
      err_q <= 1'b0;
      tcnt_q <= '0;
    end else begin
      clk_s_q <= {clk_s_q[0], ps2_clk};
      dat_s_q <= {dat_s_q[0], ps2_data};
      clk_prev_q <= clk_s_q[1];
      state_q <= state_d;
      bitcnt_q <= bitcnt_d;
      shreg_q <= shreg_d;
      par_ok_q <= par_ok_d;
      brk_q <= brk_d;
      err_q <= err_d;
      tcnt_q <= tcnt_d;
    end
  assign err = err_q;
  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push_i(push),
    .din_i(shreg_q),
    .pop_i(kr),
    .dout_o(kd),
    .valid_o(kv),
    .ovf_o(overflow)
  );
endmodule

// File: tb/tb_ps2_kbd_rx.sv
// tb_ps2_kbd_rx: directed PS/2 frame scenarios against a filtering and a pass-through receiver.
module tb_ps2_kbd_rx;
  localparam int H = 20;
  localparam int TMO = 100;
  logic clk = 1'b0, rst_n = 1'b0, ps2_clk = 1'b1, ps2_data = 1'b1, kr = 1'b0, kr0 = 1'b0;
  logic [7:0] kd, kd0;
  logic kv, kv0, err, err0, overflow, overflow0;
  int tests_run = 0, fails = 0, err_cnt = 0, ovf_cnt = 0;

  always #5 clk = ~clk;

  ps2_kbd_rx #(.DEPTH(4), .TIMEOUT_CYCLES(TMO), .DROP_BREAK(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kr(kr),
    .kd(kd), .kv(kv), .err(err), .overflow(overflow));

  ps2_kbd_rx #(.DEPTH(4), .TIMEOUT_CYCLES(TMO), .DROP_BREAK(1'b0)) dut_pass (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .kr(kr0),
    .kd(kd0), .kv(kv0), .err(err0), .overflow(overflow0));

  always @(posedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  // pop_here raises kr for exactly the cycle in which the stop-bit fall is seen
  task automatic send_bit(input logic b, input bit pop_here);
    ps2_data = b;
    repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b0;
    if (pop_here) begin
      @(posedge clk);
      @(posedge clk);
      #1 kr = 1'b1;
      @(posedge clk);
      #1 kr = 1'b0;
      repeat (H - 3) @(posedge clk);
    end else repeat (H) @(posedge clk);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_at_stop);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit(~^b ^ bad_par, 1'b0);
    send_bit(1'b1, pop_at_stop);
    repeat (10) @(posedge clk);
  endtask

  task automatic pop1(output logic [7:0] d, output logic v);
    @(negedge clk);
    v = kv;
    d = kd;
    if (v) kr = 1'b1;
    @(negedge clk);
    kr = 1'b0;
  endtask

  task automatic pop0(output logic [7:0] d, output logic v);
    @(negedge clk);
    v = kv0;
    d = kd0;
    if (v) kr0 = 1'b1;
    @(negedge clk);
    kr0 = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({kv, kd, err, overflow} !== 11'd0) begin
      fails++;
      $display("FAIL reset_outputs: kv=%b kd=%h err=%b ovf=%b, want all 0", kv, kd, err, overflow);
    end
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_basic();
    int e0;
    logic [7:0] d;
    logic v;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    @(negedge clk);
    tests_run++;
    if (kv !== 1'b1) begin fails++; $display("FAIL basic_kv: got %b want 1", kv); end
    tests_run++;
    if (kd !== 8'h1C) begin fails++; $display("FAIL basic_kd: got %h want 1c", kd); end
    pop1(d, v);
    @(negedge clk);
    tests_run++;
    if (kv !== 1'b0) begin fails++; $display("FAIL basic_pop_kv: got %b want 0", kv); end
    tests_run++;
    if (err_cnt - e0 !== 0) begin fails++; $display("FAIL basic_err: got %0d pulses want 0", err_cnt - e0); end
  endtask

  task automatic test_parity();
    int e0;
    logic [7:0] d;
    logic v;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL parity_err: got %0d pulses want 1", err_cnt - e0); end
    tests_run++;
    if (kv !== 1'b0) begin fails++; $display("FAIL parity_kv: got %b want 0", kv); end
    send_frame(8'h32, 1'b0, 1'b0);
    pop1(d, v);
    tests_run++;
    if ({v, d} !== {1'b1, 8'h32}) begin fails++; $display("FAIL parity_next: got v=%b d=%h want v=1 d=32", v, d); end
  endtask

  task automatic test_break();
    logic [7:0] seq [4];
    logic [7:0] d;
    logic v;
    seq = '{8'hF0, 8'h1C, 8'hE0, 8'h75};
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(seq[i], 1'b0, 1'b0);
    for (int i = 2; i < 4; i++) begin
      pop1(d, v);
      tests_run++;
      if ({v, d} !== {1'b1, seq[i]}) begin fails++; $display("FAIL break_drop[%0d]: got v=%b d=%h want %h", i, v, d, seq[i]); end
    end
    pop1(d, v);
    tests_run++;
    if (v !== 1'b0) begin fails++; $display("FAIL break_drop_empty: got kv=%b d=%h want kv=0", v, d); end
    for (int i = 0; i < 4; i++) begin
      pop0(d, v);
      tests_run++;
      if ({v, d} !== {1'b1, seq[i]}) begin fails++; $display("FAIL break_pass[%0d]: got v=%b d=%h want %h", i, v, d, seq[i]); end
    end
  endtask

  task automatic test_overflow();
    int o0;
    logic [7:0] d;
    logic v;
    do_reset();
    for (int pass = 0; pass < 2; pass++) begin
      o0 = ovf_cnt;
      for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
      if (pass == 0) begin
        tests_run++;
        if (ovf_cnt - o0 !== 0) begin fails++; $display("FAIL ovf_early: got %0d pulses want 0", ovf_cnt - o0); end
      end
      send_frame(8'h05, 1'b0, pass == 1);
      tests_run++;
      if (ovf_cnt - o0 !== (pass == 0 ? 1 : 0)) begin
        fails++;
        $display("FAIL ovf_pulse[%0d]: got %0d pulses want %0d", pass, ovf_cnt - o0, pass == 0 ? 1 : 0);
      end
      for (int i = 1; i <= 4; i++) begin
        pop1(d, v);
        tests_run++;
        if ({v, d} !== {1'b1, 8'(i + pass)}) begin
          fails++;
          $display("FAIL ovf_pop[%0d][%0d]: got v=%b d=%h want %h", pass, i, v, d, 8'(i + pass));
        end
      end
      pop1(d, v);
      tests_run++;
      if (v !== 1'b0) begin fails++; $display("FAIL ovf_empty[%0d]: got kv=%b want 0", pass, v); end
    end
  endtask

  task automatic test_timeout();
    int e0;
    logic [7:0] d;
    logic v;
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    repeat (3 * TMO) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if (err_cnt - e0 !== 1) begin fails++; $display("FAIL timeout_err: got %0d pulses want 1", err_cnt - e0); end
    tests_run++;
    if (kv !== 1'b0) begin fails++; $display("FAIL timeout_kv: got %b want 0", kv); end
    send_frame(8'h29, 1'b0, 1'b0);
    pop1(d, v);
    tests_run++;
    if ({v, d} !== {1'b1, 8'h29}) begin fails++; $display("FAIL timeout_next: got v=%b d=%h want 29", v, d); end
  endtask

  task automatic test_reset_mid();
    int e0;
    logic [7:0] d;
    logic v;
    e0 = err_cnt;
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 6; i++) send_bit(i[0], 1'b0);
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({kv, kd, err, overflow} !== 11'd0) begin
      fails++;
      $display("FAIL midreset_outputs: kv=%b kd=%h err=%b ovf=%b, want all 0", kv, kd, err, overflow);
    end
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send_frame(8'h5A, 1'b0, 1'b0);
    pop1(d, v);
    tests_run++;
    if ({v, d} !== {1'b1, 8'h5A}) begin fails++; $display("FAIL midreset_byte: got v=%b d=%h want 5a", v, d); end
    pop1(d, v);
    tests_run++;
    if (v !== 1'b0) begin fails++; $display("FAIL midreset_empty: got kv=%b want 0", v); end
    tests_run++;
    if (err_cnt - e0 !== 0) begin fails++; $display("FAIL midreset_err: got %0d pulses want 0", err_cnt - e0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_overflow();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
